nco_bank: RTL

Multi-channel numerically controlled oscillator bank: NCH independent ACC_W-bit phase accumulators in one clock domain. Each has a runtime-loadable frequency word, a phase offset, a linear frequency-sweep mode and a phase reset. Per channel it outputs a THETA_W-bit phase word for the SinCos lookup, a square-wave MSB for the TX PLL and a wrap pulse. It replaces the single fixed-increment NCO in the receiver/transmitter top level. All configuration goes through a valid/ready port.

---
 rtl/nco_bank.sv | 101 ++++++++++
 1 files changed

// File: rtl/nco_bank.sv
// NCH-channel phase-accumulator NCO bank (phase + offset, sweep, phase reset); outputs registered, acc-to-theta 1 cycle.
// Config valid/ready: cfg_ready drops for one cycle after each accepted write, so at most one write per 2 cycles.
module nco_bank #(
    parameter int NCH     = 4,
    parameter int ACC_W   = 64,
    parameter int THETA_W = 10,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [1:0]             cfg_op,
    input  logic [ACC_W-1:0]       cfg_data,
    input  logic [NCH-1:0]         sweep_en,
    output logic [NCH*THETA_W-1:0] theta,
    output logic [NCH-1:0]         sq_out,
    output logic [NCH-1:0]         wrap
);
    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_OFF  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;

    logic cfg_ready_q;
    logic cfg_ready_d;
    logic xfer;

    assign xfer        = cfg_valid & cfg_ready_q;
    assign cfg_ready_d = ~xfer;
    assign cfg_ready   = cfg_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [ACC_W-1:0]   acc_q, acc_d;
        logic [ACC_W-1:0]   inc_q, inc_d;
        logic [ACC_W-1:0]   off_q, off_d;
        logic [ACC_W-1:0]   step_q, step_d;
        logic [ACC_W:0]     sum;
        logic [THETA_W-1:0] theta_q, theta_d;
        logic               sq_q;
        logic               wrap_q, wrap_d;
        logic               hit;

        // Out-of-range channel indices match no instance, so they are accepted but inert.
        assign hit = xfer && (cfg_ch == CH_W'(g));
        assign sum = {1'b0, acc_q} + {1'b0, inc_q};
        // Output phase uses the accumulator value before this edge's update.
        assign theta_d = THETA_W'((acc_q + off_q) >> (ACC_W - THETA_W));

        always_comb begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
            inc_d  = sweep_en[g] ? inc_q + step_q : inc_q;
            off_d  = off_q;
            step_d = step_q;
            if (hit) begin
                case (cfg_op)
                    OP_INC:  inc_d  = cfg_data;
                    OP_OFF:  off_d  = cfg_data;
                    OP_STEP: step_d = cfg_data;
                    default: begin
                        acc_d  = '0;
                        wrap_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q   <= '0;
                inc_q   <= '0;
                off_q   <= '0;
                step_q  <= '0;
                theta_q <= '0;
                sq_q    <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                inc_q   <= inc_d;
                off_q   <= off_d;
                step_q  <= step_d;
                theta_q <= theta_d;
                sq_q    <= theta_d[THETA_W-1];
                wrap_q  <= wrap_d;
            end
        end

        assign theta[g*THETA_W +: THETA_W] = theta_q;
        assign sq_out[g]                   = sq_q;
        assign wrap[g]                     = wrap_q;
    end
endmodule
